cache_ctrl_nway: RTL and testbench
==================================

// Module: cache_ctrl_nway
// PURPOSE
//  Parametrised write-back/write-allocate controller for an N-way set-associative cache.
//  Drives a tag/data/valid/dirty datapath with one-hot per-way load vectors and a tree-PLRU.
//  Prefers invalid ways on fill, latches the victim for the whole miss, counts hits/misses.
//  Sits between a requester (L1 or CPU port) and physical memory; usable as L1 or L2.
// PARAMETERS
//  WAYS   4   associativity; power of 2, >=2
//  CNT_W  32  width of hit/miss performance counters
//  (derived) WS=$clog2(WAYS) way-index width; LW=WAYS-1 PLRU tree bits
// PORTS
//  clk             in   1     clock
//  rst             in   1     synchronous, active-high reset
//  mem_read        in   1     requester read; held until mem_resp
//  mem_write       in   1     requester write; held until mem_resp
//  mem_resp        out  1     request complete (1-cycle pulse)
//  pmem_read       out  1     memory line read; held until pmem_resp
//  pmem_write      out  1     memory line write-back; held until pmem_resp
//  pmem_resp       in   1     memory transfer complete
//  hit             in   WAYS  per-way tag match AND valid
//  valid_out       in   WAYS  per-way valid bit of indexed set
//  dirty_out       in   WAYS  per-way dirty bit of indexed set
//  lru_out         in   LW    PLRU bits of indexed set
//  load_data/load_tag/load_valid/load_dirty  out  WAYS each  one-hot per-way array writes
//  valid_in        out  1     value written on load_valid
//  dirty_in        out  1     value written on load_dirty
//  way_sel         out  WS    way feeding rdata / pmem_wdata mux
//  load_lru        out  1     write lru_in to indexed set
//  lru_in          out  LW    updated PLRU bits
//  data_sel        out  1     0: line from pmem, 1: merge requester write data
//  load_pmem_wdata out  1     capture selected way into write-back buffer
//  hit_count       out  CNT_W saturating hit count
//  miss_count      out  CNT_W saturating miss count
// BEHAVIOUR
//  Reset: state=LOOKUP, victim_q=0, miss_pend_q=0, counters=0; while rst=1 every output except counters is 0.
//  PLRU: heap-indexed tree, node i children 2i+1/2i+2, leaf way w = node-(WAYS-1).
//   Victim: walk from root, bit 0 -> left, 1 -> right. Access to w: each node on w's path points away from w (left child taken -> 1).
//  Default all outputs 0. Read has priority if mem_read and mem_write are both high.
//  LOOKUP, no request: idle.
//  LOOKUP hit (w = lowest set hit bit): same cycle mem_resp=1, way_sel=w, load_lru=1, lru_in=touch(lru_out,w).
//   Write hit adds data_sel=1, load_data[w], load_dirty[w], dirty_in=1. Stays LOOKUP.
//   hit_count++ only if miss_pend_q=0; miss_pend_q cleared.
//  LOOKUP miss: victim = lowest invalid way, else PLRU victim; latch victim_q; miss_count++; miss_pend_q=1.
//   valid_out[v]&dirty_out[v] -> WRITE_BACK, else FILL. No outputs asserted this cycle except counters.
//  WRITE_BACK: way_sel=victim_q, load_pmem_wdata=1, pmem_write=1.
//   On pmem_resp: load_dirty[victim_q], dirty_in=0 -> FILL.
//  FILL: way_sel=victim_q, pmem_read=1. Array loads only in the pmem_resp cycle:
//   load_data/tag/valid/dirty[victim_q], valid_in=1, dirty_in=0, data_sel=0 -> LOOKUP (access then hits).
//  victim_q is stable from miss detection until return to LOOKUP; lru_out changes mid-miss are ignored.
//  Request dropped mid-miss: transfer still completes, then LOOKUP idles; no mem_resp issued.
//  Counters saturate at all-ones; they do not wrap.
//  Reset mid-WRITE_BACK/FILL: pmem_read/write low from the rst cycle; no array loads.
//  Latency: hit 0 cycles; clean miss 1+Tmem+1; dirty miss 1+2*Tmem+1.
// STRUCTURE
//  cache_pkg: state enum {LOOKUP, WRITE_BACK, FILL}; functions first_one(), all-ones helpers.
//  Sub-module cache_plru_tree #(WAYS): combinational; lru_out -> victim; (lru_out, way) -> lru_in.
// TESTING (WAYS=4 unless noted)
//  Read, hit=4'b0100, lru_out=3'b000 -> same-cycle mem_resp, way_sel=2, lru_in=3'b001, hit_count=1.
//  Write, hit=4'b0010 -> load_data=4'b0010, load_dirty=4'b0010, dirty_in=1, data_sel=1, mem_resp.
//  Miss, valid_out=4'b1011 -> FILL on way 2 regardless of lru_out; load_* only in pmem_resp cycle; then hit, hit_count unchanged.
//  Miss, all valid, lru_out=3'b000, dirty_out=4'b0001 -> WRITE_BACK way 0 (pmem_write, load_pmem_wdata), then FILL way 0, miss_count=1.
//  rst pulse mid-FILL after 3 wait cycles -> pmem_read=0 next cycle, state LOOKUP, counters 0.
//  WAYS=8, CNT_W=2: 5 misses -> miss_count saturates at 3; victim walk matches reference PLRU model.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and helpers for the N-way cache controller
//
// Purpose: controller state encoding plus small combinational helpers
//   state_e      : LOOKUP / WRITE_BACK / FILL
//   first_one()  : index of the lowest set bit of a vector (0 when none set)
//   ones()       : all-ones mask of a given width, used for counter saturation
package cache_pkg;

  typedef enum logic [1:0] {
    LOOKUP     = 2'd0,
    WRITE_BACK = 2'd1,
    FILL       = 2'd2
  } state_e;

  // Scans from the top down so the lowest set bit is the one that sticks.
  function automatic logic [4:0] first_one(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = i[4:0];
    end
    return idx;
  endfunction

  function automatic logic [63:0] ones(input int w);
    logic [63:0] m;
    if (w >= 64) m = '1;
    else         m = (64'd1 << w) - 64'd1;
    return m;
  endfunction

endpackage

// File: rtl/cache_plru_tree.sv
// rtl/cache_plru_tree.sv - combinational tree-PLRU victim select and touch update
//
// Purpose: heap-indexed PLRU tree for one set. Node i has children 2i+1 / 2i+2,
//   leaf way w sits at node w+WAYS-1. Node i is stored at bit LW-1-i, so the
//   root is the MSB of the LRU vector.
// Ports:
//   lru_out   in  LW  current PLRU bits of the indexed set
//   touch_way in  WS  way being accessed
//   victim    out WS  way reached walking from the root (0 -> left, 1 -> right)
//   lru_in    out LW  lru_out with every node on touch_way's path pointing away from it
module cache_plru_tree #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         lru_out,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  output logic [$clog2(WAYS)-1:0] victim,
  output logic [WAYS-2:0]         lru_in
);
  import cache_pkg::*;

  localparam int WS = $clog2(WAYS);
  localparam int LW = WAYS - 1;

  // Level l holds nodes (2^l - 1) .. (2^(l+1) - 2). The node on a path at
  // level l is selected by the top l bits of the way index, so each node is
  // visited with a constant index and matched against that prefix.
  always_comb begin
    victim = '0;
    for (int l = 0; l < WS; l++) begin
      for (int n = (1 << l) - 1; n < (2 << l) - 1; n++) begin
        if (int'(victim >> (WS - l)) == n - ((1 << l) - 1))
          victim[WS-1-l] = lru_out[LW-1-n];
      end
    end
  end

  // Taking the left child (way bit 0) leaves the node pointing right (1).
  always_comb begin
    lru_in = lru_out;
    for (int l = 0; l < WS; l++) begin
      for (int n = (1 << l) - 1; n < (2 << l) - 1; n++) begin
        if (int'(touch_way >> (WS - l)) == n - ((1 << l) - 1))
          lru_in[LW-1-n] = ~touch_way[WS-1-l];
      end
    end
  end

endmodule

// File: rtl/cache_ctrl_nway.sv
// rtl/cache_ctrl_nway.sv - write-back/write-allocate N-way set-associative cache controller
//
// Purpose: sequences lookup, dirty write-back and line fill for an N-way cache,
//   driving one-hot per-way array loads and a tree-PLRU, with saturating
//   hit/miss counters.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_read/mem_write/mem_resp   requester handshake (read wins when both high)
//   pmem_read/pmem_write/pmem_resp memory line transfer handshake
//   hit/valid_out/dirty_out/lru_out  per-way status of the indexed set
//   load_data/tag/valid/dirty     one-hot per-way array write strobes
//   valid_in/dirty_in             values written on load_valid/load_dirty
//   way_sel                       way feeding the read / write-back mux
//   load_lru/lru_in               PLRU update of the indexed set
//   data_sel                      0: line from memory, 1: merge requester data
//   load_pmem_wdata               capture selected way into write-back buffer
//   hit_count/miss_count          saturating performance counters
module cache_ctrl_nway #(
  parameter int WAYS  = 4,
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read,
  input  logic                    mem_write,
  output logic                    mem_resp,
  output logic                    pmem_read,
  output logic                    pmem_write,
  input  logic                    pmem_resp,
  input  logic [WAYS-1:0]         hit,
  input  logic [WAYS-1:0]         valid_out,
  input  logic [WAYS-1:0]         dirty_out,
  input  logic [WAYS-2:0]         lru_out,
  output logic [WAYS-1:0]         load_data,
  output logic [WAYS-1:0]         load_tag,
  output logic [WAYS-1:0]         load_valid,
  output logic [WAYS-1:0]         load_dirty,
  output logic                    valid_in,
  output logic                    dirty_in,
  output logic [$clog2(WAYS)-1:0] way_sel,
  output logic                    load_lru,
  output logic [WAYS-2:0]         lru_in,
  output logic                    data_sel,
  output logic                    load_pmem_wdata,
  output logic [CNT_W-1:0]        hit_count,
  output logic [CNT_W-1:0]        miss_count
);
  import cache_pkg::*;

  localparam int WS = $clog2(WAYS);
  localparam int LW = WAYS - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ones(CNT_W));

  state_e          state_q;
  logic [WS-1:0]   victim_q;
  logic            miss_pend_q;

  logic            req;
  logic            is_write;
  logic            any_hit;
  logic            any_invalid;
  logic [WAYS-1:0] invalid;
  logic [WAYS-1:0] hit_oh;
  logic [WAYS-1:0] vic_oh;
  logic [WS-1:0]   hit_way;
  logic [WS-1:0]   inv_way;
  logic [WS-1:0]   plru_victim;
  logic [WS-1:0]   miss_way;
  logic [LW-1:0]   lru_touch;

  assign req         = mem_read | mem_write;
  assign is_write    = mem_write & ~mem_read;
  assign any_hit     = |hit;
  assign invalid     = ~valid_out;
  assign any_invalid = |invalid;
  assign hit_way     = WS'(first_one(32'(hit)));
  assign inv_way     = WS'(first_one(32'(invalid)));
  // Isolate the lowest set hit bit so multiple matches still give a one-hot load.
  assign hit_oh      = hit & (~hit + {{(WAYS-1){1'b0}}, 1'b1});
  assign miss_way    = any_invalid ? inv_way : plru_victim;

  always_comb begin
    vic_oh           = '0;
    vic_oh[victim_q] = 1'b1;
  end

  cache_plru_tree #(.WAYS(WAYS)) u_plru (
    .lru_out   (lru_out),
    .touch_way (hit_way),
    .victim    (plru_victim),
    .lru_in    (lru_touch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOOKUP;
      victim_q    <= '0;
      miss_pend_q <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      case (state_q)
        LOOKUP: begin
          if (req) begin
            if (any_hit) begin
              // The hit that completes a miss is not a new hit.
              if (!miss_pend_q && hit_count != CNT_MAX)
                hit_count <= hit_count + 1'b1;
              miss_pend_q <= 1'b0;
            end else begin
              victim_q    <= miss_way;
              miss_pend_q <= 1'b1;
              if (miss_count != CNT_MAX)
                miss_count <= miss_count + 1'b1;
              if (valid_out[miss_way] && dirty_out[miss_way])
                state_q <= WRITE_BACK;
              else
                state_q <= FILL;
            end
          end
        end
        WRITE_BACK: if (pmem_resp) state_q <= FILL;
        FILL:       if (pmem_resp) state_q <= LOOKUP;
        default:    state_q <= LOOKUP;
      endcase
    end
  end

  // Outputs are decoded from state and inputs so a hit completes in the
  // request cycle; all are forced low while rst is held.
  always_comb begin
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    load_data       = '0;
    load_tag        = '0;
    load_valid      = '0;
    load_dirty      = '0;
    valid_in        = 1'b0;
    dirty_in        = 1'b0;
    way_sel         = '0;
    load_lru        = 1'b0;
    lru_in          = '0;
    data_sel        = 1'b0;
    load_pmem_wdata = 1'b0;
    if (!rst) begin
      case (state_q)
        LOOKUP: begin
          if (req && any_hit) begin
            mem_resp = 1'b1;
            way_sel  = hit_way;
            load_lru = 1'b1;
            lru_in   = lru_touch;
            if (is_write) begin
              data_sel   = 1'b1;
              load_data  = hit_oh;
              load_dirty = hit_oh;
              dirty_in   = 1'b1;
            end
          end
        end
        WRITE_BACK: begin
          way_sel         = victim_q;
          load_pmem_wdata = 1'b1;
          pmem_write      = 1'b1;
          if (pmem_resp) begin
            load_dirty = vic_oh;
            dirty_in   = 1'b0;
          end
        end
        FILL: begin
          way_sel   = victim_q;
          pmem_read = 1'b1;
          if (pmem_resp) begin
            load_data  = vic_oh;
            load_tag   = vic_oh;
            load_valid = vic_oh;
            load_dirty = vic_oh;
            valid_in   = 1'b1;
            dirty_in   = 1'b0;
            data_sel   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// tb/tb_cache_ctrl_nway.sv - directed bench for cache_ctrl_nway (4-way and 8-way/2-bit counters)
module tb_cache_ctrl_nway;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-way instance
  logic       rd, wr, presp;
  logic [3:0] hit4, val4, dir4;
  logic [2:0] lru4;
  logic       resp4, pread4, pwrite4, vin4, din4, llru4, dsel4, lpw4;
  logic [3:0] ld4, lt4, lv4, ldy4;
  logic [1:0] way4;
  logic [2:0] lruin4;
  logic [31:0] hc4, mc4;

  // 8-way instance with 2-bit counters
  logic       rd8, wr8, presp8;
  logic [7:0] hit8, val8, dir8;
  logic [6:0] lru8;
  logic       resp8, pread8, pwrite8, vin8, din8, llru8, dsel8, lpw8;
  logic [7:0] ld8, lt8, lv8, ldy8;
  logic [2:0] way8;
  logic [6:0] lruin8;
  logic [1:0] hc8, mc8;

  cache_ctrl_nway #(.WAYS(4), .CNT_W(32)) u4 (
    .clk(clk), .rst(rst), .mem_read(rd), .mem_write(wr), .mem_resp(resp4),
    .pmem_read(pread4), .pmem_write(pwrite4), .pmem_resp(presp),
    .hit(hit4), .valid_out(val4), .dirty_out(dir4), .lru_out(lru4),
    .load_data(ld4), .load_tag(lt4), .load_valid(lv4), .load_dirty(ldy4),
    .valid_in(vin4), .dirty_in(din4), .way_sel(way4), .load_lru(llru4),
    .lru_in(lruin4), .data_sel(dsel4), .load_pmem_wdata(lpw4),
    .hit_count(hc4), .miss_count(mc4)
  );

  cache_ctrl_nway #(.WAYS(8), .CNT_W(2)) u8 (
    .clk(clk), .rst(rst), .mem_read(rd8), .mem_write(wr8), .mem_resp(resp8),
    .pmem_read(pread8), .pmem_write(pwrite8), .pmem_resp(presp8),
    .hit(hit8), .valid_out(val8), .dirty_out(dir8), .lru_out(lru8),
    .load_data(ld8), .load_tag(lt8), .load_valid(lv8), .load_dirty(ldy8),
    .valid_in(vin8), .dirty_in(din8), .way_sel(way8), .load_lru(llru8),
    .lru_in(lruin8), .data_sel(dsel8), .load_pmem_wdata(lpw8),
    .hit_count(hc8), .miss_count(mc8)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [3:0] hit;
    logic [2:0] lru;
    logic       resp;
    logic [1:0] way;
    logic [2:0] lru_in;
    logic [3:0] ld;
    logic       din;
    logic       dsel;
  } vec_t;

  typedef struct {
    logic [7:0] valid;
    logic [6:0] lru;
    logic [2:0] way;
  } miss8_t;

  vec_t   vt[7];
  miss8_t mt[6];
  int     nh;
  int     exp_mc8;

  initial begin
    // lru bit order: root is MSB
    vt[0] = '{1'b1, 1'b0, 4'b0100, 3'b000, 1'b1, 2'd2, 3'b001, 4'b0000, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 4'b0010, 3'b000, 1'b1, 2'd1, 3'b100, 4'b0010, 1'b1, 1'b1};
    vt[2] = '{1'b1, 1'b0, 4'b1000, 3'b111, 1'b1, 2'd3, 3'b010, 4'b0000, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b1, 4'b0001, 3'b000, 1'b1, 2'd0, 3'b110, 4'b0000, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b0, 4'b0110, 3'b101, 1'b1, 2'd1, 3'b101, 4'b0000, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b0, 4'b1111, 3'b101, 1'b0, 2'd0, 3'b000, 4'b0000, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b1, 4'b1000, 3'b010, 1'b1, 2'd3, 3'b010, 4'b1000, 1'b1, 1'b1};

    mt[0] = '{8'hFF, 7'b0000000, 3'd0};
    mt[1] = '{8'hFF, 7'b1000000, 3'd4};
    mt[2] = '{8'hFF, 7'b1010010, 3'd6};
    mt[3] = '{8'hFF, 7'b0100100, 3'd3};
    mt[4] = '{8'hFF, 7'b1111111, 3'd7};
    mt[5] = '{8'b11011111, 7'b1111111, 3'd5};

    rd = 1'b0; wr = 1'b0; presp = 1'b0;
    hit4 = '0; val4 = '0; dir4 = '0; lru4 = '0;
    rd8 = 1'b0; wr8 = 1'b0; presp8 = 1'b0;
    hit8 = '0; val8 = '0; dir8 = '0; lru8 = '0;

    // Reset: outputs held low even with a hitting request present
    rst = 1'b1;
    tick();
    rd = 1'b1; hit4 = 4'b0100; val4 = 4'hF;
    #1;
    chk("rst_mem_resp", 64'(resp4), 64'(0));
    chk("rst_load_lru", 64'(llru4), 64'(0));
    chk("rst_way_sel", 64'(way4), 64'(0));
    tick();
    rst = 1'b0; rd = 1'b0; hit4 = '0;
    #1;
    chk("rst_hit_count", 64'(hc4), 64'(0));
    chk("rst_miss_count", 64'(mc4), 64'(0));

    // Table of LOOKUP-cycle vectors
    nh = 0;
    for (int i = 0; i < 7; i++) begin
      rd = vt[i].rd; wr = vt[i].wr; hit4 = vt[i].hit; lru4 = vt[i].lru;
      val4 = 4'hF; dir4 = 4'h0;
      #1;
      chk($sformatf("v%0d_mem_resp", i), 64'(resp4), 64'(vt[i].resp));
      chk($sformatf("v%0d_way_sel", i), 64'(way4), 64'(vt[i].way));
      chk($sformatf("v%0d_load_lru", i), 64'(llru4), 64'(vt[i].resp));
      chk($sformatf("v%0d_lru_in", i), 64'(lruin4), 64'(vt[i].lru_in));
      chk($sformatf("v%0d_load_data", i), 64'(ld4), 64'(vt[i].ld));
      chk($sformatf("v%0d_load_dirty", i), 64'(ldy4), 64'(vt[i].ld));
      chk($sformatf("v%0d_dirty_in", i), 64'(din4), 64'(vt[i].din));
      chk($sformatf("v%0d_data_sel", i), 64'(dsel4), 64'(vt[i].dsel));
      chk($sformatf("v%0d_load_valid", i), 64'(lv4), 64'(0));
      chk($sformatf("v%0d_pmem_read", i), 64'(pread4), 64'(0));
      if (vt[i].rd || vt[i].wr) nh++;
      tick();
    end
    rd = 1'b0; wr = 1'b0; hit4 = '0;
    #1;
    chk("table_hit_count", 64'(hc4), 64'(nh));
    chk("table_miss_count", 64'(mc4), 64'(0));

    // Clean miss: way 2 invalid wins over PLRU (which points at way 0)
    rd = 1'b1; hit4 = '0; val4 = 4'b1011; dir4 = 4'b1111; lru4 = 3'b000;
    #1;
    chk("cm_miss_resp", 64'(resp4), 64'(0));
    chk("cm_miss_pread", 64'(pread4), 64'(0));
    chk("cm_miss_ld", 64'(ld4), 64'(0));
    tick();
    chk("cm_miss_count", 64'(mc4), 64'(1));
    chk("cm_fill_pread", 64'(pread4), 64'(1));
    chk("cm_fill_pwrite", 64'(pwrite4), 64'(0));
    chk("cm_fill_way", 64'(way4), 64'(2));
    lru4 = 3'b111;
    #1;
    chk("cm_latched_way", 64'(way4), 64'(2));
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("cm_wait%0d_pread", i), 64'(pread4), 64'(1));
      chk($sformatf("cm_wait%0d_lv", i), 64'(lv4), 64'(0));
    end
    presp = 1'b1;
    #1;
    chk("cm_resp_ld", 64'(ld4), 64'(4'b0100));
    chk("cm_resp_lt", 64'(lt4), 64'(4'b0100));
    chk("cm_resp_lv", 64'(lv4), 64'(4'b0100));
    chk("cm_resp_ldy", 64'(ldy4), 64'(4'b0100));
    chk("cm_resp_vin", 64'(vin4), 64'(1));
    chk("cm_resp_din", 64'(din4), 64'(0));
    chk("cm_resp_dsel", 64'(dsel4), 64'(0));
    tick();
    presp = 1'b0; hit4 = 4'b0100; val4 = 4'hF;
    #1;
    chk("cm_rehit_resp", 64'(resp4), 64'(1));
    chk("cm_rehit_way", 64'(way4), 64'(2));
    tick();
    rd = 1'b0; hit4 = '0;
    #1;
    chk("cm_hit_count_kept", 64'(hc4), 64'(nh));

    // Dirty miss: all valid, PLRU -> way 0, way 0 dirty; request dropped during fill
    rd = 1'b1; hit4 = '0; val4 = 4'hF; dir4 = 4'b0001; lru4 = 3'b000;
    #1;
    chk("dm_miss_pwrite", 64'(pwrite4), 64'(0));
    tick();
    chk("dm_wb_pwrite", 64'(pwrite4), 64'(1));
    chk("dm_wb_lpw", 64'(lpw4), 64'(1));
    chk("dm_wb_way", 64'(way4), 64'(0));
    chk("dm_wb_pread", 64'(pread4), 64'(0));
    chk("dm_wb_ldy", 64'(ldy4), 64'(0));
    lru4 = 3'b110;
    presp = 1'b1;
    #1;
    chk("dm_wbresp_ldy", 64'(ldy4), 64'(4'b0001));
    chk("dm_wbresp_din", 64'(din4), 64'(0));
    chk("dm_wbresp_ld", 64'(ld4), 64'(0));
    tick();
    presp = 1'b0;
    #1;
    chk("dm_fill_pread", 64'(pread4), 64'(1));
    chk("dm_fill_pwrite", 64'(pwrite4), 64'(0));
    chk("dm_fill_way", 64'(way4), 64'(0));
    chk("dm_fill_ld", 64'(ld4), 64'(0));
    rd = 1'b0;
    presp = 1'b1;
    #1;
    chk("dm_fillresp_ld", 64'(ld4), 64'(4'b0001));
    tick();
    presp = 1'b0;
    #1;
    chk("dm_dropped_resp", 64'(resp4), 64'(0));
    chk("dm_idle_pread", 64'(pread4), 64'(0));
    chk("dm_miss_count", 64'(mc4), 64'(2));

    // Reset in the middle of a fill
    rd = 1'b1; hit4 = '0; val4 = 4'b0111; dir4 = 4'h0;
    tick();
    chk("rf_fill_way", 64'(way4), 64'(3));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rf_wait%0d_pread", i), 64'(pread4), 64'(1));
    end
    rst = 1'b1; presp = 1'b1;
    #1;
    chk("rf_rst_pread", 64'(pread4), 64'(0));
    chk("rf_rst_lv", 64'(lv4), 64'(0));
    chk("rf_rst_ld", 64'(ld4), 64'(0));
    tick();
    rst = 1'b0; presp = 1'b0; rd = 1'b0;
    #1;
    chk("rf_after_pread", 64'(pread4), 64'(0));
    chk("rf_after_hc", 64'(hc4), 64'(0));
    chk("rf_after_mc", 64'(mc4), 64'(0));
    rd = 1'b1; hit4 = 4'b0100; val4 = 4'hF; lru4 = 3'b000;
    #1;
    chk("rf_lookup_resp", 64'(resp4), 64'(1));
    tick();
    rd = 1'b0; hit4 = '0;
    #1;
    chk("rf_lookup_hc", 64'(hc4), 64'(1));

    // 8-way: victim walk and saturating 2-bit miss counter
    exp_mc8 = 0;
    for (int i = 0; i < 6; i++) begin
      rd8 = 1'b1; hit8 = '0; val8 = mt[i].valid; dir8 = '0; lru8 = mt[i].lru;
      #1;
      chk($sformatf("w8_m%0d_pread_miss", i), 64'(pread8), 64'(0));
      tick();
      if (exp_mc8 < 3) exp_mc8++;
      chk($sformatf("w8_m%0d_way", i), 64'(way8), 64'(mt[i].way));
      chk($sformatf("w8_m%0d_pread", i), 64'(pread8), 64'(1));
      chk($sformatf("w8_m%0d_mc", i), 64'(mc8), 64'(exp_mc8));
      presp8 = 1'b1;
      #1;
      chk($sformatf("w8_m%0d_lv", i), 64'(lv8), 64'(8'd1 << mt[i].way));
      tick();
      presp8 = 1'b0; rd8 = 1'b0;
    end
    rd8 = 1'b1; hit8 = 8'b00100000; val8 = 8'hFF; lru8 = 7'b0000000;
    #1;
    chk("w8_touch_way", 64'(way8), 64'(5));
    chk("w8_touch_lru_in", 64'(lruin8), 64'(7'b0010000));
    tick();
    rd8 = 1'b0; hit8 = '0;
    #1;
    chk("w8_final_mc", 64'(mc8), 64'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
